// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, bubble encoding and
// word-alignment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction that returned while decode was
// stalled; clear wins over load.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_data,
  input  logic [31:0] load_pc4,
  output logic [31:0] data,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      data  <= NOP_INST_DEFAULT;
      pc4   <= 32'd0;
      valid <= 1'b0;
    end else if (clear) begin
      data  <= NOP_INST_DEFAULT;
      pc4   <= 32'd0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      pc4   <= load_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register and a one-entry skid buffer
// absorbing a response that lands while decode is stalled.
//
// state  | meaning
// FETCH  | request outstanding at pc every cycle
// HOLD   | response parked in skid buffer, waiting for decode to drain
// HALTED | halt seen in decode; no requests until reset
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        has_hazard,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halted,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        fetch_halted
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_inc;
  logic [31:0]  inst_nxt, pc_plus4_nxt;
  logic         inst_valid_nxt;
  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_data, skid_pc4;

  assign pc_inc = pc + 32'd4;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst_b     (rst_b),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (imem_rdata),
    .load_pc4  (pc_inc),
    .data      (skid_data),
    .pc4       (skid_pc4),
    .valid     (skid_valid)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      pc_plus4   <= 32'd0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      pc_plus4   <= pc_plus4_nxt;
      inst_valid <= inst_valid_nxt;
    end
  end

  // Priority: HALTED freeze > redirect > halt > stall/response
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    inst_nxt       = inst;
    pc_plus4_nxt   = pc_plus4;
    inst_valid_nxt = inst_valid;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (state == HALTED) begin
      state_nxt = HALTED;
    end else if (redirect_valid) begin
      state_nxt      = FETCH;
      pc_nxt         = align_word(redirect_target);
      inst_nxt       = NOP_INST;
      inst_valid_nxt = 1'b0;
      skid_clear     = 1'b1;
    end else if (halted && inst_valid) begin
      state_nxt      = HALTED;
      inst_nxt       = NOP_INST;
      inst_valid_nxt = 1'b0;
      skid_clear     = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (has_hazard) begin
            if (imem_ready) begin
              skid_load = 1'b1;
              pc_nxt    = pc_inc;
              state_nxt = HOLD;
            end
          end else if (imem_ready) begin
            inst_nxt       = imem_rdata;
            pc_plus4_nxt   = pc_inc;
            inst_valid_nxt = 1'b1;
            pc_nxt         = pc_inc;
          end else begin
            inst_nxt       = NOP_INST;
            inst_valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!has_hazard) begin
            inst_nxt       = skid_data;
            pc_plus4_nxt   = skid_pc4;
            inst_valid_nxt = skid_valid;
            skid_clear     = 1'b1;
            state_nxt      = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req     = (state == FETCH);
    imem_addr    = pc;
    fetch_halted = (state == HALTED);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one task per scenario with inline checks.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        has_hazard;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;
  logic [31:0] inst;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        fetch_halted;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .has_hazard      (has_hazard),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .inst            (inst),
    .pc_plus4        (pc_plus4),
    .inst_valid      (inst_valid),
    .fetch_halted    (fetch_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; imem_ready = 1'b0; has_hazard = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0; halted = 1'b0;
    #12;
    checks++; if (inst !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", inst, NOP); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want 0", pc_plus4); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", fetch_halted); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_req got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1;
    step();
    checks++; if (inst !== 32'h2008_0005 || pc_plus4 !== 32'h4 || inst_valid !== 1'b1) begin errors++; $display("FAIL seq_first got inst=%h pc4=%h v=%b want 20080005/4/1", inst, pc_plus4, inst_valid); end
    step();
    checks++; if (inst !== 32'h2009_0003 || pc_plus4 !== 32'h8 || inst_valid !== 1'b1) begin errors++; $display("FAIL seq_second got inst=%h pc4=%h v=%b want 20090003/8/1", inst, pc_plus4, inst_valid); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr got %h want 8", imem_addr); end
  endtask

  task automatic test_hazard();
    has_hazard = 1'b1;
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req cyc %0d got %b want 0", i, imem_req); end
      checks++; if (inst !== 32'h2009_0003 || pc_plus4 !== 32'h8 || inst_valid !== 1'b1) begin errors++; $display("FAIL hold_ifid cyc %0d got %h/%h/%b want 20090003/8/1", i, inst, pc_plus4, inst_valid); end
    end
    has_hazard = 1'b0;
    step();
    checks++; if (inst !== mem_word(32'h8) || pc_plus4 !== 32'hC || inst_valid !== 1'b1) begin errors++; $display("FAIL hold_release got %h/%h/%b want %h/c/1", inst, pc_plus4, inst_valid, mem_word(32'h8)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL hold_next got req=%b addr=%h want 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_bubble();
    imem_ready = 1'b0;
    step();
    checks++; if (inst !== NOP || inst_valid !== 1'b0 || imem_addr !== 32'hC) begin errors++; $display("FAIL bubble1 got %h/%b addr=%h want 0/0/c", inst, inst_valid, imem_addr); end
    halted = 1'b1;
    step();
    checks++; if (inst !== NOP || inst_valid !== 1'b0 || imem_addr !== 32'hC) begin errors++; $display("FAIL bubble2 got %h/%b addr=%h want 0/0/c", inst, inst_valid, imem_addr); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL halt_needs_valid got %b want 0", fetch_halted); end
    halted = 1'b0;
    imem_ready = 1'b1;
    step();
    checks++; if (inst !== mem_word(32'hC) || pc_plus4 !== 32'h10 || inst_valid !== 1'b1) begin errors++; $display("FAIL bubble_resume got %h/%h/%b want %h/10/1", inst, pc_plus4, inst_valid, mem_word(32'hC)); end
  endtask

  task automatic test_redirect_fetch();
    imem_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin errors++; $display("FAIL redir_kill got %h/%b want 0/0", inst, inst_valid); end
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_addr got %h/%b want 40/1", imem_addr, imem_req); end
    redirect_valid = 1'b0;
    step();
    checks++; if (inst !== mem_word(32'h40) || pc_plus4 !== 32'h44 || inst_valid !== 1'b1) begin errors++; $display("FAIL redir_first got %h/%h/%b want %h/44/1", inst, pc_plus4, inst_valid, mem_word(32'h40)); end
  endtask

  task automatic test_redirect_hold();
    has_hazard = 1'b1; imem_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rhold_enter got %b want 0", imem_req); end
    redirect_valid = 1'b1; redirect_target = 32'h82;
    step();
    checks++; if (imem_addr !== 32'h80 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL rhold_redir got %h/%b/%b want 80/1/0", imem_addr, imem_req, inst_valid); end
    redirect_valid = 1'b0; has_hazard = 1'b0; imem_ready = 1'b0;
    step();
    checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin errors++; $display("FAIL rhold_drop got %h/%b want 0/0", inst, inst_valid); end
    imem_ready = 1'b1;
    step();
    checks++; if (inst !== mem_word(32'h80) || pc_plus4 !== 32'h84) begin errors++; $display("FAIL rhold_fetch got %h/%h want %h/84", inst, pc_plus4, mem_word(32'h80)); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    checks++; if (pc_plus4 !== 32'h0 || imem_addr !== 32'h0 || inst !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap got pc4=%h addr=%h inst=%h want 0/0/%h", pc_plus4, imem_addr, inst, mem_word(32'hFFFF_FFFC)); end
  endtask

  task automatic test_halt();
    halted = 1'b1;
    step();
    checks++; if (fetch_halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP) begin errors++; $display("FAIL halt_enter got h=%b req=%b v=%b inst=%h want 1/0/0/0", fetch_halted, imem_req, inst_valid, inst); end
    halted = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h100;
    step();
    redirect_valid = 1'b0;
    step(); step();
    checks++; if (fetch_halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL halt_sticky got h=%b req=%b v=%b want 1/0/0", fetch_halted, imem_req, inst_valid); end
    #2 rst_b = 1'b0;
    #1;
    checks++; if (fetch_halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL halt_reset got h=%b req=%b addr=%h want 0/1/0", fetch_halted, imem_req, imem_addr); end
    @(negedge clk);
    rst_b = 1'b1;
    imem_ready = 1'b1;
    step();
    checks++; if (inst !== 32'h2008_0005 || pc_plus4 !== 32'h4 || inst_valid !== 1'b1) begin errors++; $display("FAIL halt_restart got %h/%h/%b want 20080005/4/1", inst, pc_plus4, inst_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hazard();
    test_bubble();
    test_redirect_fetch();
    test_redirect_hold();
    test_wrap();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
